// File: rtl/gost89_cfb.sv
// GOST 28147-89 cipher-feedback (gamma with feedback) stream wrapper.
// One 64-bit block is processed at a time through a single encrypt-only
// ECB core. Decryption reuses the same core, because CFB only ever needs
// the forward cipher to produce the keystream.
`timescale 1ns/1ps

// Iterative GOST 28147-89 ECB encryption core, one round per clock.
// The block is split as n1 = in[31:0], n2 = in[63:32]. The key words are
// K0..K7 = key[31:0] .. key[255:224], used forward for rounds 0-23 and
// reversed for rounds 24-31. S-box j occupies sbox[64*j +: 64], and the
// entry for nibble value v is sbox[64*j + 4*v +: 4].
// busy rises on the load edge and stays high for 33 cycles: 32 rounds
// plus one cycle to publish the result.
module gost89_ecb_encrypt (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_data,
    input  logic [511:0] sbox,
    input  logic [255:0] key,
    input  logic [63:0]  in,
    output logic [63:0]  out,
    output logic         busy
);

    logic [31:0] n1;
    logic [31:0] n2;
    logic [5:0]  cnt;
    logic [2:0]  kidx;
    logic [31:0] round_key;
    logic [31:0] sum;
    logic [31:0] sub;
    logic [31:0] f_out;

    // Round function: key add, S-box substitution, then rotate left by 11.
    // The last eight rounds walk the key words in reverse order.
    always_comb begin
        kidx      = (cnt[4:3] == 2'b11) ? ~cnt[2:0] : cnt[2:0];
        round_key = key[{kidx, 5'b00000} +: 32];
        sum       = n1 + round_key;
        sub       = '0;
        for (int i = 0; i < 8; i++) begin
            sub[4*i +: 4] = sbox[{i[2:0], sum[4*i +: 4], 2'b00} +: 4];
        end
        f_out = (sub << 11) | (sub >> 21);
    end

    // Round state: load on load_data, run 32 rounds, then publish and go idle.
    // Publishing {n1, n2} undoes the swap performed by the last round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n1   <= '0;
            n2   <= '0;
            cnt  <= '0;
            out  <= '0;
            busy <= 1'b0;
        end else if (load_data) begin
            n1   <= in[31:0];
            n2   <= in[63:32];
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == 6'd32) begin
                out  <= {n1, n2};
                busy <= 1'b0;
            end else begin
                n1  <= n2 ^ f_out;
                n2  <= n1;
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule

// CFB wrapper: accepts a block, encrypts the feedback register to obtain
// the gamma, XORs it with the data and updates the feedback register.
module gost89_cfb #(
    parameter logic [63:0] IV_RESET = 64'h0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic [511:0] sbox,
    input  logic [255:0] key,
    input  logic [63:0]  iv,
    input  logic         iv_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RUN,
        OUTPUT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [63:0] fb;
    logic [63:0] dat;
    logic        md;
    logic        core_load;
    logic        core_busy;
    logic [63:0] core_out;
    logic [63:0] gamma_xor;

    assign gamma_xor = dat ^ core_out;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    // The core sees the feedback register directly; it samples it on the
    // START cycle, so an iv loaded on the accept edge is already in place.
    gost89_ecb_encrypt u_core (
        .clk       (clk),
        .reset     (~reset_n),
        .load_data (core_load),
        .sbox      (sbox),
        .key       (key),
        .in        (fb),
        .out       (core_out),
        .busy      (core_busy)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the single-cycle core load strobe.
    always_comb begin
        next_state = state;
        core_load  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = START;
                end
            end
            START: begin
                core_load  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (core_busy) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!core_busy) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture the block, apply gamma, chain the feedback register
    // (ciphertext in both directions) and hold the result until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb        <= IV_RESET;
            dat       <= '0;
            md        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iv_load) begin
                        fb <= iv;
                    end
                    if (in_valid) begin
                        dat <= in_data;
                        md  <= mode;
                    end
                end
                RUN: begin
                    if (!core_busy) begin
                        out_data  <= gamma_xor;
                        out_valid <= 1'b1;
                        fb        <= md ? dat : gamma_xor;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/gost89_cfb.md
Name: gost89_cfb

Overview:
- GOST 28147-89 cipher-feedback (gamma with feedback) mode wrapper for streaming 64-bit blocks in either direction.
- Contains one gost89_ecb_encrypt core and acts as its initiator: drives load_data and in, waits on busy, takes out.
- XORs the keystream ("gamma") with the data and maintains the feedback register.
- Sits between the block-stream interface (valid/ready) and the ECB core. Decryption also uses the encrypt core only.

Parameters:
- IV_RESET, 64'h0, value the feedback register takes on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = encrypt, 1 = decrypt; sampled when a block is accepted.
- sbox  input  512  S-box table, passed straight to the core.
- key  input  256  cipher key, passed straight to the core; must be stable while busy.
- iv  input  64  initialisation vector.
- iv_load  input  1  load iv into the feedback register (IDLE only).
- in_valid  input  1  input block valid.
- in_ready  output  1  input block accepted when in_valid && in_ready.
- in_data  input  64  plaintext (encrypt) or ciphertext (decrypt).
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  64  result block.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n low, async):
  - State = IDLE; fb = IV_RESET; out_valid = 0; out_data = 0; in_ready = 1; busy = 0.
  - Core reset input = ~reset_n, so the core is held in reset while reset_n is low. Core busy reads 0 after release.
- Registers:
  - fb[63:0]: feedback register, fed to core.in.
  - dat[63:0]: latched in_data.
  - md: latched mode.
- States and transitions:
  - IDLE: in_ready = 1.
    - iv_load → fb <= iv.
    - in_valid → dat <= in_data, md <= mode, go START.
    - iv_load and in_valid in the same cycle: fb <= iv, and the block uses the new iv.
  - START: core.load_data = 1 for exactly this one cycle; go WAIT.
  - WAIT: if core busy == 1, go RUN (one cycle in practice).
  - RUN: when core busy == 0:
    - gamma = core.out.
    - out_data <= dat ^ gamma; out_valid <= 1.
    - fb <= (md == 0) ? (dat ^ gamma) : dat. Encrypt feeds back ciphertext; decrypt feeds back the received ciphertext.
    - Go OUTPUT.
  - OUTPUT: hold out_valid and out_data stable until out_ready. On the handshake: out_valid <= 0, go IDLE.
- Signals outside START and IDLE:
  - core.load_data = 0 outside START.
  - in_ready = 0 outside IDLE.
  - iv_load is ignored outside IDLE.
- Latency: 35 cycles from the accept edge to the edge that sets out_valid (core busy spans load edge + 33 cycles). This latency is constant for every block.
- Throughput: one block per 37 cycles when out_ready is tied high. There is no gamma precomputation and no overlap.
- Back-pressure: out_ready low holds OUTPUT indefinitely. The core is idle then, and no further block is accepted.
- Mode, key and sbox changes mid-block do not affect the block in flight for mode (it is latched). key and sbox are the caller's responsibility.
- Reset mid-block: the block is discarded, fb returns to IV_RESET, and no out_valid is produced. After release, the first accepted block starts cleanly.
- Width rules: all XOR is 64-bit bitwise. Halves are taken as the core presents them, with no byte swapping.

Test Plan:
- Zero-plaintext gamma:
  - Stimulus: reset; load iv = 64'h0123456789ABCDEF; encrypt 3 blocks of 64'h0.
  - Required: outputs G1, G2, G3 with G1 = core E(iv), G2 = E(G1), G3 = E(G2), each cross-checked against a standalone gost89_ecb_encrypt.
  - Required: each out_valid exactly 35 cycles after acceptance.
- Round trip:
  - Stimulus: encrypt 64'hDEADBEEFCAFEF00D, 64'h0, 64'hFFFFFFFFFFFFFFFF with the iv above; reload the same iv; decrypt the three ciphertexts with mode = 1.
  - Required: the original three plaintexts are returned.
- Linearity of first block:
  - Stimulus: same iv; encrypt P = 64'h1 and, after reloading iv, P = 64'h3.
  - Required: the two ciphertexts differ by exactly 64'h2.
- Back-pressure:
  - Stimulus: out_ready held low for 50 cycles after out_valid.
  - Required: out_data stable, in_ready = 0, busy = 1, and in_valid ignored. After out_ready, the next block proceeds normally with correct chaining.
- Reset mid-block:
  - Stimulus: assert reset_n low at cycle 20 of a block.
  - Required: out_valid never rises and fb = IV_RESET. The next encrypt of 64'h0 yields E(64'h0).
- Simultaneous iv_load and in_valid in IDLE:
  - Required: the block uses the new iv, and iv_load during RUN has no effect on chaining.
